// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits (first bit -> data_out[0]),
// optional parity bit and stop bit, sampled one bit per clk edge with en=1.
module serial_frame_receiver #(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  output logic [0:WIDTH-1] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic           ODD  = (ODD_PARITY != 0);
  localparam logic           HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [0:WIDTH-1] shift;
  logic             par_bit;
  logic             take_bit;
  logic             deliver;
  logic             stop_bad;
  logic             par_mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // BREAK absorbs a stuck-low line so it is never mistaken for repeated start bits.
  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    if (en) begin
      case (state)
        S_IDLE: begin
          if (!sin) state_next = S_DATA;
        end
        S_DATA: begin
          take_bit = 1'b1;
          if (cnt == LAST) state_next = HAS_PAR ? S_PARITY : S_STOP;
        end
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          if (sin) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = S_BREAK;
          end
        end
        S_BREAK: begin
          if (sin) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign par_mismatch = HAS_PAR && ((^shift ^ par_bit) != ODD);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= deliver;
      frame_err <= stop_bad;
      if (en && state == S_IDLE && !sin) cnt <= '0;
      if (take_bit) begin
        shift[cnt] <= sin;
        cnt        <= cnt + CW'(1);
      end
      if (en && state == S_PARITY) par_bit <= sin;
      if (deliver) begin
        data_out   <= shift;
        parity_err <= par_mismatch;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed self-checking bench for serial_frame_receiver (WIDTH=4, even parity).
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sin;
  logic [0:3] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int valid_cnt;
  int ferr_cnt;
  int busy_low_cnt;

  serial_frame_receiver #(.WIDTH(4), .PARITY_EN(1), .ODD_PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sin(sin),
    .data_out(data_out), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock: drive on the falling edge, observe 1 ns after the rising edge.
  task automatic step(input logic e, input logic b);
    @(negedge clk);
    en  = e;
    sin = b;
    @(posedge clk);
    #1;
    if (valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (busy !== 1'b1) busy_low_cnt++;
  endtask

  task automatic clear_counts();
    valid_cnt    = 0;
    ferr_cnt     = 0;
    busy_low_cnt = 0;
  endtask

  task automatic send_frame(input logic [0:3] d, input logic p);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, d[i]);
    step(1'b1, p);
    step(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    sin   = 1'b1;
    clear_counts();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    n_cmp++;
    if ({data_out, valid, parity_err, frame_err, busy} !== 8'b0000_0000) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got data=%b v=%b pe=%b fe=%b busy=%b, expected all 0",
               data_out, valid, parity_err, frame_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    clear_counts();
    step(1'b1, 1'b1);
    send_frame(4'b1001, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || data_out !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL good_frame_data: got v=%b data=%b, expected v=1 data=1001", valid, data_out);
    end
    n_cmp++;
    if (parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL good_frame_flags: got pe=%b fe=%b busy=%b, expected 0 0 0",
               parity_err, frame_err, busy);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (valid_cnt != 1 || ferr_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL good_frame_pulses: got valid=%0d ferr=%0d, expected 1 0", valid_cnt, ferr_cnt);
    end
  endtask

  task automatic test_parity_err();
    clear_counts();
    send_frame(4'b1001, 1'b1);
    n_cmp++;
    if (valid !== 1'b1 || data_out !== 4'b1001 || parity_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL parity_err: got v=%b data=%b pe=%b, expected 1 1001 1",
               valid, data_out, parity_err);
    end
    step(1'b1, 1'b1);
  endtask

  task automatic test_frame_err();
    clear_counts();
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL frame_err_stop: got fe=%b v=%b busy=%b, expected 1 0 1", frame_err, valid, busy);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (busy_low_cnt != 0 || ferr_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL frame_err_break: got busy_low=%0d ferr=%0d, expected 0 1", busy_low_cnt, ferr_cnt);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL frame_err_release: got busy=%b, expected 0", busy);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (valid_cnt != 0 || data_out !== 4'b1001 || parity_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL frame_err_hold: got valid=%0d data=%b pe=%b, expected 0 1001 1",
               valid_cnt, data_out, parity_err);
    end
  endtask

  task automatic test_en_toggle();
    logic [0:6] bits;
    bits = 7'b0_0110_0_1;
    clear_counts();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[i]);
      step(1'b0, bits[i]);
    end
    n_cmp++;
    if (data_out !== 4'b0110 || parity_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL en_toggle_data: got data=%b pe=%b, expected 0110 0", data_out, parity_err);
    end
    n_cmp++;
    if (valid_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL en_toggle_pulse: got %0d valid cycles, expected 1", valid_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    clear_counts();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    sin   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || data_out !== 4'b0000 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset: got busy=%b data=%b v=%b, expected 0 0000 0", busy, data_out, valid);
    end
    step(1'b1, 1'b1);
    send_frame(4'b1100, 1'b0);
    step(1'b1, 1'b1);
    n_cmp++;
    if (data_out !== 4'b1100 || valid_cnt != 1 || ferr_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL midframe_recover: got data=%b valid=%0d ferr=%0d, expected 1100 1 0",
               data_out, valid_cnt, ferr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(4'b1010, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || data_out !== 4'b1010) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got v=%b data=%b, expected 1 1010", valid, data_out);
    end
    send_frame(4'b0101, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || data_out !== 4'b0101 || parity_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got v=%b data=%b pe=%b, expected 1 0101 0", valid, data_out, parity_err);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (valid_cnt != 2 || ferr_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_pulses: got valid=%0d ferr=%0d, expected 2 0", valid_cnt, ferr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_en_toggle();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
